fetch_stage: RTL and testbench

Instruction fetch stage. It is the producer side of the decoder input interface (instr, pc, ce, stall, flush). It generates the PC and issues requests to instruction memory over a req/ack handshake. Fetched instruction/PC pairs go to the decoder. The stage honours downstream stall and flush, and accepts PC redirects from later stages (branch, jump, trap).

---
 rtl/fetch_stage_if.sv | 26 ++
 rtl/fetch_stage.sv | 180 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-side bus bundle: instruction memory req/ack channel plus the
// instruction/PC channel toward the decoder (with its stall/flush returns).
interface fetch_stage_if #(
    parameter int unsigned PC_WIDTH = 32,
    parameter int unsigned IWIDTH   = 32
);
    logic                f_o_imem_req;
    logic [PC_WIDTH-1:0] f_o_imem_addr;
    logic                f_i_imem_ack;
    logic [IWIDTH-1:0]   f_i_imem_data;
    logic                f_i_stall;
    logic                f_i_flush;
    logic [IWIDTH-1:0]   f_o_instr;
    logic [PC_WIDTH-1:0] f_o_pc;
    logic                f_o_ce;

    modport master (
        output f_o_imem_req, f_o_imem_addr, f_o_instr, f_o_pc, f_o_ce,
        input  f_i_imem_ack, f_i_imem_data, f_i_stall, f_i_flush
    );

    modport slave (
        input  f_o_imem_req, f_o_imem_addr, f_o_instr, f_o_pc, f_o_ce,
        output f_i_imem_ack, f_i_imem_data, f_i_stall, f_i_flush
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC generation, single-outstanding req/ack fetch
// from instruction memory, one-entry stall buffer, redirect and flush handling.
module fetch_stage #(
    parameter int unsigned          PC_WIDTH = 32,
    parameter int unsigned          IWIDTH   = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = 32'h0000_0000
) (
    input  logic                f_clk,
    input  logic                f_rst,
    input  logic                f_i_ce,
    input  logic                f_i_change_pc,
    input  logic [PC_WIDTH-1:0] f_i_new_pc,
    fetch_stage_if.master       bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_BUF
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

    state_t              state_q,     state_d;
    logic [PC_WIDTH-1:0] pc_q,        pc_d;
    logic                req_q,       req_d;
    logic [PC_WIDTH-1:0] addr_q,      addr_d;
    logic [IWIDTH-1:0]   instr_q,     instr_d;
    logic [PC_WIDTH-1:0] opc_q,       opc_d;
    logic                ce_q,        ce_d;
    logic [IWIDTH-1:0]   buf_instr_q, buf_instr_d;
    logic [PC_WIDTH-1:0] buf_pc_q,    buf_pc_d;
    logic                discard_q,   discard_d;
    logic                halted_q,    halted_d;

    logic ack;
    logic stall;

    assign ack   = bus.f_i_imem_ack;
    assign stall = bus.f_i_stall;

    // State register; reset drops req at once so any pending ack is ignored.
    always_ff @(posedge f_clk or negedge f_rst) begin
        if (!f_rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            req_q       <= 1'b0;
            addr_q      <= RESET_PC;
            instr_q     <= '0;
            opc_q       <= '0;
            ce_q        <= 1'b0;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
            discard_q   <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            instr_q     <= instr_d;
            opc_q       <= opc_d;
            ce_q        <= ce_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            discard_q   <= discard_d;
            halted_q    <= halted_d;
        end
    end

    // Next-state logic: redirect beats flush, flush beats normal operation.
    // The buffer is full exactly when in S_BUF, so leaving S_BUF empties it.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_d       = req_q;
        addr_d      = addr_q;
        instr_d     = instr_q;
        opc_d       = opc_q;
        ce_d        = ce_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        discard_d   = discard_q;
        halted_d    = halted_q;

        // Outputs hold under stall; otherwise valid only when something is delivered.
        if (!stall) begin
            ce_d = 1'b0;
        end

        if (f_i_change_pc) begin
            pc_d      = f_i_new_pc;
            ce_d      = 1'b0;
            halted_d  = 1'b0;
            discard_d = 1'b0;
            if (state_q == S_REQ && !ack) begin
                // Request cannot be withdrawn: let it finish on the old address, then drop it.
                discard_d = 1'b1;
            end else if (state_q == S_REQ) begin
                if (f_i_ce) begin
                    addr_d = f_i_new_pc;
                end else begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end else begin
                req_d   = 1'b0;
                state_d = S_IDLE;
            end
        end else if (bus.f_i_flush) begin
            ce_d     = 1'b0;
            halted_d = 1'b1;
            if (state_q == S_REQ && !ack) begin
                discard_d = 1'b1;
            end else begin
                discard_d = 1'b0;
                req_d     = 1'b0;
                state_d   = S_IDLE;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (f_i_ce && !stall && !halted_q) begin
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                        state_d = S_REQ;
                    end
                end
                S_REQ: begin
                    if (ack) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                            if (f_i_ce && !halted_q) begin
                                addr_d = pc_q;
                            end else begin
                                req_d   = 1'b0;
                                state_d = S_IDLE;
                            end
                        end else if (stall) begin
                            buf_instr_d = bus.f_i_imem_data;
                            buf_pc_d    = addr_q;
                            pc_d        = addr_q + PC_STEP;
                            req_d       = 1'b0;
                            state_d     = S_BUF;
                        end else begin
                            instr_d = bus.f_i_imem_data;
                            opc_d   = addr_q;
                            ce_d    = 1'b1;
                            pc_d    = addr_q + PC_STEP;
                            if (f_i_ce) begin
                                addr_d = addr_q + PC_STEP;
                            end else begin
                                req_d   = 1'b0;
                                state_d = S_IDLE;
                            end
                        end
                    end
                end
                S_BUF: begin
                    if (!stall) begin
                        instr_d = buf_instr_q;
                        opc_d   = buf_pc_q;
                        ce_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign bus.f_o_imem_req  = req_q;
    assign bus.f_o_imem_addr = addr_q;
    assign bus.f_o_instr     = instr_q;
    assign bus.f_o_pc        = opc_q;
    assign bus.f_o_ce        = ce_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        rst_w_n;
    logic        ce;
    logic        chg;
    logic [31:0] npc;
    logic        stall;
    logic        flush;
    logic        zw;
    logic        ack_m;

    int unsigned n_assert;
    int unsigned n_fail;

    fetch_stage_if #(.PC_WIDTH(32), .IWIDTH(32)) bus_a ();
    fetch_stage_if #(.PC_WIDTH(32), .IWIDTH(32)) bus_w ();

    // Memory contents: word at address a is a ^ 32'hC0DE_0000.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign bus_a.f_i_imem_ack  = zw ? bus_a.f_o_imem_req : ack_m;
    assign bus_a.f_i_imem_data = mem(bus_a.f_o_imem_addr);
    assign bus_a.f_i_stall     = stall;
    assign bus_a.f_i_flush     = flush;

    assign bus_w.f_i_imem_ack  = bus_w.f_o_imem_req;
    assign bus_w.f_i_imem_data = mem(bus_w.f_o_imem_addr);
    assign bus_w.f_i_stall     = 1'b0;
    assign bus_w.f_i_flush     = 1'b0;

    fetch_stage #(.PC_WIDTH(32), .IWIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .f_clk         (clk),
        .f_rst         (rst_n),
        .f_i_ce        (ce),
        .f_i_change_pc (chg),
        .f_i_new_pc    (npc),
        .bus           (bus_a)
    );

    fetch_stage #(.PC_WIDTH(32), .IWIDTH(32), .RESET_PC(32'hFFFF_FFF8)) dut_w (
        .f_clk         (clk),
        .f_rst         (rst_w_n),
        .f_i_ce        (1'b1),
        .f_i_change_pc (1'b0),
        .f_i_new_pc    (32'h0),
        .bus           (bus_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n = 1'b0; rst_w_n = 1'b0; ce = 1'b0; chg = 1'b0; npc = '0;
        stall = 1'b0; flush = 1'b0; zw = 1'b1; ack_m = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_req",   32'(bus_a.f_o_imem_req), 32'h0);
        chk("rst_addr",  bus_a.f_o_imem_addr,     32'h0);
        chk("rst_ce",    32'(bus_a.f_o_ce),       32'h0);
        chk("rst_pc",    bus_a.f_o_pc,            32'h0);
        chk("rst_instr", bus_a.f_o_instr,         32'h0);
        chk("rstw_addr", bus_w.f_o_imem_addr,     32'hFFFF_FFF8);
        chk("rstw_pc",   bus_w.f_o_pc,            32'h0);

        // 1: zero-wait streaming from reset
        ce = 1'b1; rst_n = 1'b1;
        tick();
        chk("t1_req",    32'(bus_a.f_o_imem_req), 32'h1);
        chk("t1_addr",   bus_a.f_o_imem_addr,     32'h0);
        chk("t1_ce0",    32'(bus_a.f_o_ce),       32'h0);
        tick();
        chk("t1_ce1",    32'(bus_a.f_o_ce),       32'h1);
        chk("t1_pc0",    bus_a.f_o_pc,            32'h0);
        chk("t1_in0",    bus_a.f_o_instr,         32'hC0DE_0000);
        tick();
        chk("t1_pc4",    bus_a.f_o_pc,            32'h4);
        chk("t1_in4",    bus_a.f_o_instr,         32'hC0DE_0004);
        tick();
        chk("t1_pc8",    bus_a.f_o_pc,            32'h8);
        chk("t1_in8",    bus_a.f_o_instr,         32'hC0DE_0008);
        chk("t1_ce2",    32'(bus_a.f_o_ce),       32'h1);

        // 2: slow ack with stall -> buffered, released later
        zw = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("t2_req0",   32'(bus_a.f_o_imem_req), 32'h1);
        ack_m = 1'b1;
        tick();
        ack_m = 1'b0;
        chk("t2_ce0",    32'(bus_a.f_o_ce),       32'h1);
        chk("t2_pc0",    bus_a.f_o_pc,            32'h0);
        tick();
        chk("t2_wce",    32'(bus_a.f_o_ce),       32'h0);
        chk("t2_waddr",  bus_a.f_o_imem_addr,     32'h4);
        chk("t2_wreq",   32'(bus_a.f_o_imem_req), 32'h1);
        stall = 1'b1;
        tick();
        ack_m = 1'b1;
        tick();
        ack_m = 1'b0;
        chk("t2_breq",   32'(bus_a.f_o_imem_req), 32'h0);
        chk("t2_bce",    32'(bus_a.f_o_ce),       32'h0);
        chk("t2_bpc",    bus_a.f_o_pc,            32'h0);
        chk("t2_bin",    bus_a.f_o_instr,         32'hC0DE_0000);
        tick();
        chk("t2_hreq",   32'(bus_a.f_o_imem_req), 32'h0);
        stall = 1'b0;
        tick();
        chk("t2_rce",    32'(bus_a.f_o_ce),       32'h1);
        chk("t2_rpc",    bus_a.f_o_pc,            32'h4);
        chk("t2_rin",    bus_a.f_o_instr,         32'hC0DE_0004);
        tick();
        chk("t2_nreq",   32'(bus_a.f_o_imem_req), 32'h1);
        chk("t2_naddr",  bus_a.f_o_imem_addr,     32'h8);
        chk("t2_nce",    32'(bus_a.f_o_ce),       32'h0);
        ce = 1'b0; ack_m = 1'b1;
        tick();
        ack_m = 1'b0;
        chk("t2_lce",    32'(bus_a.f_o_ce),       32'h1);
        chk("t2_lpc",    bus_a.f_o_pc,            32'h8);
        chk("t2_lreq",   32'(bus_a.f_o_imem_req), 32'h0);
        tick();
        chk("t2_ice",    32'(bus_a.f_o_ce),       32'h0);
        chk("t2_ireq",   32'(bus_a.f_o_imem_req), 32'h0);

        // 3: redirect while request to 0x10 is in flight
        ce = 1'b1; zw = 1'b1; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick(); tick(); tick();
        zw = 1'b0;
        chk("t3_addr",   bus_a.f_o_imem_addr,     32'h10);
        chk("t3_pc",     bus_a.f_o_pc,            32'hC);
        chg = 1'b1; npc = 32'h200;
        tick();
        chg = 1'b0;
        chk("t3_haddr",  bus_a.f_o_imem_addr,     32'h10);
        chk("t3_hreq",   32'(bus_a.f_o_imem_req), 32'h1);
        chk("t3_hce",    32'(bus_a.f_o_ce),       32'h0);
        tick();
        chk("t3_haddr2", bus_a.f_o_imem_addr,     32'h10);
        ack_m = 1'b1;
        tick();
        ack_m = 1'b0; zw = 1'b1;
        chk("t3_daddr",  bus_a.f_o_imem_addr,     32'h200);
        chk("t3_dreq",   32'(bus_a.f_o_imem_req), 32'h1);
        chk("t3_dce",    32'(bus_a.f_o_ce),       32'h0);
        tick();
        chk("t3_nce",    32'(bus_a.f_o_ce),       32'h1);
        chk("t3_npc",    bus_a.f_o_pc,            32'h200);
        chk("t3_nin",    bus_a.f_o_instr,         32'hC0DE_0200);

        // 4: flush halts fetching until a redirect
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_ce",     32'(bus_a.f_o_ce),       32'h0);
        chk("t4_req",    32'(bus_a.f_o_imem_req), 32'h0);
        tick(); tick();
        chk("t4_hreq",   32'(bus_a.f_o_imem_req), 32'h0);
        chk("t4_hce",    32'(bus_a.f_o_ce),       32'h0);
        chg = 1'b1; npc = 32'h80;
        tick();
        chg = 1'b0;
        chk("t4_rreq",   32'(bus_a.f_o_imem_req), 32'h0);
        tick();
        chk("t4_nreq",   32'(bus_a.f_o_imem_req), 32'h1);
        chk("t4_naddr",  bus_a.f_o_imem_addr,     32'h80);
        tick();
        chk("t4_ce1",    32'(bus_a.f_o_ce),       32'h1);
        chk("t4_pc",     bus_a.f_o_pc,            32'h80);
        chk("t4_in",     bus_a.f_o_instr,         32'hC0DE_0080);

        // 5: PC wrap at the top of the address space
        rst_w_n = 1'b1;
        tick();
        chk("t5_req",    32'(bus_w.f_o_imem_req), 32'h1);
        chk("t5_addr",   bus_w.f_o_imem_addr,     32'hFFFF_FFF8);
        tick();
        chk("t5_pc0",    bus_w.f_o_pc,            32'hFFFF_FFF8);
        chk("t5_in0",    bus_w.f_o_instr,         32'h3F21_FFF8);
        tick();
        chk("t5_pc1",    bus_w.f_o_pc,            32'hFFFF_FFFC);
        chk("t5_in1",    bus_w.f_o_instr,         32'h3F21_FFFC);
        tick();
        chk("t5_pc2",    bus_w.f_o_pc,            32'h0000_0000);
        chk("t5_in2",    bus_w.f_o_instr,         32'hC0DE_0000);
        chk("t5_addr2",  bus_w.f_o_imem_addr,     32'h0000_0004);

        // 6: asynchronous reset while waiting for ack, late ack ignored
        rst_n = 1'b0; zw = 1'b1;
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        zw = 1'b0;
        chk("t6_pc",     bus_a.f_o_pc,            32'h4);
        chk("t6_addr",   bus_a.f_o_imem_addr,     32'h8);
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_areq",   32'(bus_a.f_o_imem_req), 32'h0);
        chk("t6_ace",    32'(bus_a.f_o_ce),       32'h0);
        chk("t6_apc",    bus_a.f_o_pc,            32'h0);
        chk("t6_aaddr",  bus_a.f_o_imem_addr,     32'h0);
        tick();
        rst_n = 1'b1; ack_m = 1'b1;
        tick();
        ack_m = 1'b0;
        chk("t6_lce",    32'(bus_a.f_o_ce),       32'h0);
        chk("t6_lreq",   32'(bus_a.f_o_imem_req), 32'h1);
        chk("t6_laddr",  bus_a.f_o_imem_addr,     32'h0);
        ack_m = 1'b1;
        tick();
        ack_m = 1'b0;
        chk("t6_fce",    32'(bus_a.f_o_ce),       32'h1);
        chk("t6_fpc",    bus_a.f_o_pc,            32'h0);
        chk("t6_fin",    bus_a.f_o_instr,         32'hC0DE_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
